// File: rtl/regfile_pkg.sv
// Shared constants and types for the 4x16 register file front end.
package regfile_pkg;
   localparam int DW   = 16;
   localparam int NREG = 4;
   localparam int AW   = 2;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_req_t;

   typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} rr_pri_e;

   function automatic logic [NREG-1:0] addr2onehot(input logic [AW-1:0] a);
      logic [NREG-1:0] oh;
      oh    = '0;
      oh[a] = 1'b1;
      return oh;
   endfunction
endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Bus bundle between the regfile front end, its two writers, the read client and the regfile.
interface regfile_access_ctrl_if;
   import regfile_pkg::*;

   logic            wa_valid;
   logic [AW-1:0]   wa_addr;
   logic [DW-1:0]   wa_data;
   logic            wa_ready;
   logic            wb_valid;
   logic [AW-1:0]   wb_addr;
   logic [DW-1:0]   wb_data;
   logic            wb_ready;
   logic            rd_req_valid;
   logic            rd_req_ready;
   logic [AW-1:0]   rd_addr;
   logic [AW-1:0]   rs_addr;
   logic [NREG-1:0] rf_reg_en;
   logic [DW-1:0]   rf_source;
   logic [AW-1:0]   rf_rd;
   logic [AW-1:0]   rf_rs;
   logic [DW-1:0]   rf_rd_q;
   logic [DW-1:0]   rf_rs_q;
   logic [DW-1:0]   rd_data;
   logic [DW-1:0]   rs_data;
   logic            rd_rsp_valid;

   modport slave (
      input  wa_valid, wa_addr, wa_data, wb_valid, wb_addr, wb_data,
             rd_req_valid, rd_addr, rs_addr, rf_rd_q, rf_rs_q,
      output wa_ready, wb_ready, rd_req_ready, rf_reg_en, rf_source,
             rf_rd, rf_rs, rd_data, rs_data, rd_rsp_valid
   );

   modport master (
      output wa_valid, wa_addr, wa_data, wb_valid, wb_addr, wb_data,
             rd_req_valid, rd_addr, rs_addr, rf_rd_q, rf_rs_q,
      input  wa_ready, wb_ready, rd_req_ready, rf_reg_en, rf_source,
             rf_rd, rf_rs, rd_data, rs_data, rd_rsp_valid
   );
endinterface

// File: rtl/regfile_access_ctrl_rr_arbiter2.sv
// Two-requester round-robin arbiter; grant is combinational and one-hot, the pointer moves only on a grant.
import regfile_pkg::*;

module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   rr_pri_e pri;

   always_comb begin
      gnt = 2'b00;
      if (req[0] && (!req[1] || pri == PRI_A)) gnt = 2'b01;
      else if (req[1])                           gnt = 2'b10;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        pri <= PRI_A;
      else if (gnt[0]) pri <= PRI_B;
      else if (gnt[1]) pri <= PRI_A;
   end
endmodule

// File: rtl/regfile_access_ctrl.sv
// Regfile front end: arbitrated write port, two-stage read pipeline, write/read hazard handling.
// Define WR_BYPASS_EN to resolve hazards by forwarding write data instead of stalling the read.
import regfile_pkg::*;

module regfile_access_ctrl (
   input  logic                  clk,
   input  logic                  rst,
   regfile_access_ctrl_if.slave  bus
);
   logic [1:0]      gnt;
   wr_req_t         wr_sel;
   logic            wr_any;
   logic            haz_rd;
   logic            haz_rs;
   logic            rd_acc;

   logic [NREG-1:0] rf_reg_en_p1;
   logic [DW-1:0]   rf_source_p1;
   logic            vld_p1;
   logic            vld_p2;
   logic [AW-1:0]   rf_rd_p1;
   logic [AW-1:0]   rf_rs_p1;

   rr_arbiter2 u_arb (
      .clk (clk),
      .rst (rst),
      .req ({bus.wb_valid, bus.wa_valid}),
      .gnt (gnt)
   );

   assign bus.wa_ready = gnt[0];
   assign bus.wb_ready = gnt[1];
   assign wr_any       = |gnt;

   always_comb begin
      wr_sel.addr = gnt[1] ? bus.wb_addr : bus.wa_addr;
      wr_sel.data = gnt[1] ? bus.wb_data : bus.wa_data;
   end

   assign haz_rd = wr_any && (wr_sel.addr == bus.rd_addr);
   assign haz_rs = wr_any && (wr_sel.addr == bus.rs_addr);

`ifdef WR_BYPASS_EN
   assign bus.rd_req_ready = 1'b1;
`else
   // The write wins: the read waits one cycle so it samples the committed value.
   assign bus.rd_req_ready = !(haz_rd || haz_rs);
`endif
   assign rd_acc = bus.rd_req_valid && bus.rd_req_ready;

   // ---- stage p1: write issue and read select ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_reg_en_p1 <= '0;
         rf_source_p1 <= '0;
         vld_p1       <= 1'b0;
         rf_rd_p1     <= '0;
         rf_rs_p1     <= '0;
      end else begin
         rf_reg_en_p1 <= wr_any ? addr2onehot(wr_sel.addr) : '0;
         if (wr_any) rf_source_p1 <= wr_sel.data;
         vld_p1 <= rd_acc;
         if (rd_acc) begin
            rf_rd_p1 <= bus.rd_addr;
            rf_rs_p1 <= bus.rs_addr;
         end
      end
   end

   // ---- stage p2: response valid, regfile data arrives ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) vld_p2 <= 1'b0;
      else      vld_p2 <= vld_p1;
   end

   assign bus.rf_reg_en    = rf_reg_en_p1;
   assign bus.rf_source    = rf_source_p1;
   assign bus.rf_rd        = rf_rd_p1;
   assign bus.rf_rs        = rf_rs_p1;
   assign bus.rd_rsp_valid = vld_p2;

`ifdef WR_BYPASS_EN
   logic          byp_rd_p1, byp_rs_p1, byp_rd_p2, byp_rs_p2;
   logic [DW-1:0] byp_data_p1, byp_data_p2;

   // ---- bypass flags travel with the read through p1/p2 ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byp_rd_p1   <= 1'b0;
         byp_rs_p1   <= 1'b0;
         byp_data_p1 <= '0;
         byp_rd_p2   <= 1'b0;
         byp_rs_p2   <= 1'b0;
         byp_data_p2 <= '0;
      end else begin
         byp_rd_p1   <= rd_acc && haz_rd;
         byp_rs_p1   <= rd_acc && haz_rs;
         byp_data_p1 <= wr_sel.data;
         byp_rd_p2   <= byp_rd_p1;
         byp_rs_p2   <= byp_rs_p1;
         byp_data_p2 <= byp_data_p1;
      end
   end

   assign bus.rd_data = !vld_p2 ? '0 : (byp_rd_p2 ? byp_data_p2 : bus.rf_rd_q);
   assign bus.rs_data = !vld_p2 ? '0 : (byp_rs_p2 ? byp_data_p2 : bus.rf_rs_q);
`else
   assign bus.rd_data = vld_p2 ? bus.rf_rd_q : '0;
   assign bus.rs_data = vld_p2 ? bus.rf_rs_q : '0;
`endif
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed table-driven bench for regfile_access_ctrl with a behavioural 4x16 regfile attached.
module tb_regfile_access_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rf_init = 1'b1;
   logic [15:0] regs [4];

   int total  = 0;
   int passed = 0;

   regfile_access_ctrl_if bus ();

   regfile_access_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Regfile: write port plus registered read ports (read-before-write on the same edge)
   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 4; i++) regs[i] <= 16'(16'hA000 + i);
      end else begin
         for (int i = 0; i < 4; i++) if (bus.rf_reg_en[i]) regs[i] <= bus.rf_source;
      end
      bus.rf_rd_q <= regs[bus.rf_rd];
      bus.rf_rs_q <= regs[bus.rf_rs];
   end

   typedef struct {
      string       name;
      logic        wa_v;  logic [1:0] wa_a; logic [15:0] wa_d;
      logic        wb_v;  logic [1:0] wb_a; logic [15:0] wb_d;
      logic        rq_v;  logic [1:0] rd_a; logic [1:0]  rs_a;
      logic        e_wa;  logic e_wb; logic e_rq;
      logic [3:0]  e_en;  logic [15:0] e_src;
      logic        e_vld; logic [15:0] e_rd; logic [15:0] e_rs;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string nm,
                      input logic wav, input logic [1:0] waa, input logic [15:0] wad,
                      input logic wbv, input logic [1:0] wba, input logic [15:0] wbd,
                      input logic rqv, input logic [1:0] rda, input logic [1:0] rsa,
                      input logic ewa, input logic ewb, input logic erq,
                      input logic [3:0] een, input logic [15:0] esrc,
                      input logic evld, input logic [15:0] erd, input logic [15:0] ers);
      vec_t v;
      v.name = nm;
      v.wa_v = wav; v.wa_a = waa; v.wa_d = wad;
      v.wb_v = wbv; v.wb_a = wba; v.wb_d = wbd;
      v.rq_v = rqv; v.rd_a = rda; v.rs_a = rsa;
      v.e_wa = ewa; v.e_wb = ewb; v.e_rq = erq;
      v.e_en = een; v.e_src = esrc;
      v.e_vld = evld; v.e_rd = erd; v.e_rs = ers;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   task automatic idle_inputs();
      bus.wa_valid = 1'b0; bus.wa_addr = 2'd0; bus.wa_data = 16'h0;
      bus.wb_valid = 1'b0; bus.wb_addr = 2'd0; bus.wb_data = 16'h0;
      bus.rd_req_valid = 1'b0; bus.rd_addr = 2'd1; bus.rs_addr = 2'd1;
   endtask

   initial begin
      idle_inputs();
      bus.rd_addr = 2'd0;
      bus.rs_addr = 2'd0;

      // Arbitration: A first, then alternating
      add("arb_first", 1,0,16'h1111, 1,3,16'h3333, 0,1,1, 1,0,1, 4'b0000,16'h0000, 0,0,0);
      add("arb_b",     1,0,16'h1111, 1,3,16'h3333, 0,1,1, 0,1,1, 4'b0001,16'h1111, 0,0,0);
      add("arb_a2",    1,0,16'h1111, 1,3,16'h3333, 0,1,1, 1,0,1, 4'b1000,16'h3333, 0,0,0);
      add("arb_b2",    1,0,16'h1111, 1,3,16'h3333, 0,1,1, 0,1,1, 4'b0001,16'h1111, 0,0,0);
      add("arb_tail",  0,0,16'h0,    0,0,16'h0,    0,1,1, 0,0,1, 4'b1000,16'h3333, 0,0,0);
      add("arb_idle",  0,0,16'h0,    0,0,16'h0,    0,1,1, 0,0,1, 4'b0000,16'h0000, 0,0,0);
      // Write R2 then read it one cycle later
      add("wr_r2",     1,2,16'h1234, 0,0,16'h0,    0,1,1, 1,0,1, 4'b0000,16'h0000, 0,0,0);
      add("rd_r2",     0,0,16'h0,    0,0,16'h0,    1,2,0, 0,0,1, 4'b0100,16'h1234, 0,0,0);
      add("rd_r2_p1",  0,0,16'h0,    0,0,16'h0,    0,1,1, 0,0,1, 4'b0000,16'h0000, 0,0,0);
      add("rsp_r2",    0,0,16'h0,    0,0,16'h0,    0,1,1, 0,0,1, 4'b0000,16'h0000, 1,16'h1234,16'h1111);
      add("rsp_r2_end",0,0,16'h0,    0,0,16'h0,    0,1,1, 0,0,1, 4'b0000,16'h0000, 0,0,0);
      // Unrelated write does not stall a read
      add("b_nostall", 0,0,16'h0,    1,3,16'h5555, 1,0,1, 0,1,1, 4'b0000,16'h0000, 0,0,0);
      add("b_issue",   0,0,16'h0,    0,0,16'h0,    0,1,1, 0,0,1, 4'b1000,16'h5555, 0,0,0);
      add("rsp_nostl", 0,0,16'h0,    0,0,16'h0,    0,1,1, 0,0,1, 4'b0000,16'h0000, 1,16'h1111,16'hA001);
      // A and B to the same register, then read with rd==rs
      add("same_a",    1,2,16'hAAAA, 1,2,16'hBBBB, 0,1,1, 1,0,1, 4'b0000,16'h0000, 0,0,0);
      add("same_b",    0,0,16'h0,    1,2,16'hBBBB, 0,1,1, 0,1,1, 4'b0100,16'hAAAA, 0,0,0);
      add("rd_eq_rs",  0,0,16'h0,    0,0,16'h0,    1,2,2, 0,0,1, 4'b0100,16'hBBBB, 0,0,0);
      add("rd_eq_p1",  0,0,16'h0,    0,0,16'h0,    0,1,1, 0,0,1, 4'b0000,16'h0000, 0,0,0);
      add("rsp_eq",    0,0,16'h0,    0,0,16'h0,    0,1,1, 0,0,1, 4'b0000,16'h0000, 1,16'hBBBB,16'hBBBB);
      add("rsp_eq_end",0,0,16'h0,    0,0,16'h0,    0,1,1, 0,0,1, 4'b0000,16'h0000, 0,0,0);
      // Same-cycle hazard on rs
`ifdef WR_BYPASS_EN
      add("haz_acc",   1,1,16'hBEEF, 0,0,16'h0,    1,0,1, 1,0,1, 4'b0000,16'h0000, 0,0,0);
      add("haz_issue", 0,0,16'h0,    0,0,16'h0,    0,1,1, 0,0,1, 4'b0010,16'hBEEF, 0,0,0);
      add("haz_rsp",   0,0,16'h0,    0,0,16'h0,    0,1,1, 0,0,1, 4'b0000,16'h0000, 1,16'h1111,16'hBEEF);
      add("haz_end",   0,0,16'h0,    0,0,16'h0,    0,1,1, 0,0,1, 4'b0000,16'h0000, 0,0,0);
`else
      add("haz_stall", 1,1,16'hBEEF, 0,0,16'h0,    1,0,1, 1,0,0, 4'b0000,16'h0000, 0,0,0);
      add("haz_acc",   0,0,16'h0,    0,0,16'h0,    1,0,1, 0,0,1, 4'b0010,16'hBEEF, 0,0,0);
      add("haz_p1",    0,0,16'h0,    0,0,16'h0,    0,1,1, 0,0,1, 4'b0000,16'h0000, 0,0,0);
      add("haz_rsp",   0,0,16'h0,    0,0,16'h0,    0,1,1, 0,0,1, 4'b0000,16'h0000, 1,16'h1111,16'hBEEF);
      add("haz_end",   0,0,16'h0,    0,0,16'h0,    0,1,1, 0,0,1, 4'b0000,16'h0000, 0,0,0);
`endif

      // Reset state
      #12;
      chk("rst_reg_en", 32'(bus.rf_reg_en), 32'h0);
      chk("rst_source", 32'(bus.rf_source), 32'h0);
      chk("rst_rf_rd",  32'(bus.rf_rd), 32'h0);
      chk("rst_rf_rs",  32'(bus.rf_rs), 32'h0);
      chk("rst_rsp_v",  32'(bus.rd_rsp_valid), 32'h0);
      chk("rst_rd_data",32'(bus.rd_data), 32'h0);
      chk("rst_rs_data",32'(bus.rs_data), 32'h0);
      chk("rst_ready",  32'({bus.wa_ready, bus.wb_ready}), 32'h0);
      chk("rst_rq_rdy", 32'(bus.rd_req_ready), 32'h1);
      @(posedge clk); #1;
      rst = 1'b1;
      rf_init = 1'b0;

      foreach (vecs[i]) begin
         @(posedge clk); #1;
         bus.wa_valid = vecs[i].wa_v; bus.wa_addr = vecs[i].wa_a; bus.wa_data = vecs[i].wa_d;
         bus.wb_valid = vecs[i].wb_v; bus.wb_addr = vecs[i].wb_a; bus.wb_data = vecs[i].wb_d;
         bus.rd_req_valid = vecs[i].rq_v; bus.rd_addr = vecs[i].rd_a; bus.rs_addr = vecs[i].rs_a;
         #4;
         chk({vecs[i].name, ".wa_ready"}, 32'(bus.wa_ready), 32'(vecs[i].e_wa));
         chk({vecs[i].name, ".wb_ready"}, 32'(bus.wb_ready), 32'(vecs[i].e_wb));
         chk({vecs[i].name, ".rq_ready"}, 32'(bus.rd_req_ready), 32'(vecs[i].e_rq));
         chk({vecs[i].name, ".reg_en"},   32'(bus.rf_reg_en), 32'(vecs[i].e_en));
         if (vecs[i].e_en != 4'b0000)
            chk({vecs[i].name, ".source"}, 32'(bus.rf_source), 32'(vecs[i].e_src));
         chk({vecs[i].name, ".rsp_v"},    32'(bus.rd_rsp_valid), 32'(vecs[i].e_vld));
         if (vecs[i].e_vld) begin
            chk({vecs[i].name, ".rd_data"}, 32'(bus.rd_data), 32'(vecs[i].e_rd));
            chk({vecs[i].name, ".rs_data"}, 32'(bus.rs_data), 32'(vecs[i].e_rs));
         end
      end

      // Reset while a granted write is on the regfile port: it must never land
      @(posedge clk); #1;
      idle_inputs();
      bus.wa_valid = 1'b1; bus.wa_addr = 2'd3; bus.wa_data = 16'hDEAD;
      #4;
      chk("r6_grant", 32'(bus.wa_ready), 32'h1);
      @(posedge clk); #1;
      bus.wa_valid = 1'b0;
      #1;
      chk("r6_en_pre", 32'(bus.rf_reg_en), 32'h8);
      rst = 1'b0;
      #1;
      chk("r6_en_async", 32'(bus.rf_reg_en), 32'h0);
      chk("r6_src_async", 32'(bus.rf_source), 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      bus.rd_req_valid = 1'b1; bus.rd_addr = 2'd3; bus.rs_addr = 2'd3;
      @(posedge clk); #1;
      bus.rd_req_valid = 1'b0;
      @(posedge clk); #5;
      chk("r6_rsp_v", 32'(bus.rd_rsp_valid), 32'h1);
      chk("r6_r3_kept", 32'(bus.rd_data), 32'h5555);
      chk("r6_r3_kept_rs", 32'(bus.rs_data), 32'h5555);
      @(posedge clk); #1;
      bus.wa_valid = 1'b1; bus.wa_addr = 2'd0; bus.wa_data = 16'h0A0A;
      bus.wb_valid = 1'b1; bus.wb_addr = 2'd0; bus.wb_data = 16'h0B0B;
      #4;
      chk("r6_ptr_a", 32'({bus.wa_ready, bus.wb_ready}), 32'h2);
      @(posedge clk); #1;
      idle_inputs();
      repeat (2) @(posedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
